// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester packet arbiter feeding one registered output slot.
// A grant is held for a whole packet (until its last beat is accepted), then
// passed to the other requester if it is waiting, otherwise back to IDLE.
// Contention from IDLE goes to the requester not served last (lp).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   inN_valid/data/last   requester N beat offer (N = 0, 1)
//   inN_ready             requester N beat accepted this cycle
//   out_valid/data/last   registered output beat
//   out_src               requester the registered beat came from
//   out_ready             downstream takes the registered beat
//   busy                  arbiter is in a GRANT state
module mux_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   lp;
  logic   lp_nxt;
  logic   slot_free;
  logic   acc0;
  logic   acc1;

  // Output slot can take a new beat when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  // State and last-served pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lp    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      lp    <= lp_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next state, pointer update and ready generation.
  always_comb begin
    state_nxt = state;
    lp_nxt    = lp;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state)
      IDLE: begin
        // lp=1 means in1 was served last, so in0 wins a tie.
        if (in0_valid && in1_valid) begin
          state_nxt = lp ? GRANT0 : GRANT1;
        end else if (in0_valid) begin
          state_nxt = GRANT0;
        end else if (in1_valid) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        in0_ready = slot_free;
        if (in0_valid && slot_free && in0_last) begin
          lp_nxt    = 1'b0;
          state_nxt = in1_valid ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        in1_ready = slot_free;
        if (in1_valid && slot_free && in1_last) begin
          lp_nxt    = 1'b1;
          state_nxt = in0_valid ? GRANT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output slot: load on accept, empty when drained without refill, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (slot_free) begin
      if (acc0) begin
        out_valid <= 1'b1;
        out_data  <= in0_data;
        out_last  <= in0_last;
        out_src   <= 1'b0;
      end else if (acc1) begin
        out_valid <= 1'b1;
        out_data  <= in1_data;
        out_last  <= in1_last;
        out_src   <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Testbench for mux_arbiter: queue-driven sources, a cycle reference model of
// the arbitration rules, directed scenarios and a randomized packet run.
module tb_mux_arbiter;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_last, in1_last;
  logic             in0_ready, in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last, out_src, out_ready, busy;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct { logic [7:0] d; logic l; int gap; } beat_t;
  typedef struct { logic [7:0] d; logic l; logic s; int c; } obs_t;

  beat_t       q0[$];
  beat_t       q1[$];
  obs_t        obs_q[$];
  logic [7:0]  exp0[$];
  logic [7:0]  exp1[$];
  bit          rdy_pat[$];
  bit          rand_rdy = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Reference model: owner -1 = nobody granted, otherwise the requester index.
  int          m_owner;
  int          m_lp;
  bit          m_ov, m_ol, m_os;
  logic [7:0]  m_od;
  bit          m_acc0, m_acc1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_lp = 1;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    m_acc0 = 0; m_acc1 = 0;
  endtask

  // One clock cycle: inputs already driven; check outputs, advance the model.
  task automatic cycle();
    bit sf, r0, r1;
    int n;
    #1;
    if (rst) model_reset();
    sf = !m_ov || out_ready;
    r0 = (m_owner == 0) && sf;
    r1 = (m_owner == 1) && sf;
    check("in0_ready", in0_ready, r0);
    check("in1_ready", in1_ready, r1);
    check("out_valid", out_valid, m_ov);
    check("busy", busy, m_owner != -1);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_last", out_last, m_ol);
      check("out_src", out_src, m_os);
    end
    if (!rst && out_valid && out_ready)
      obs_q.push_back('{d: out_data, l: out_last, s: out_src, c: cyc});
    m_acc0 = r0 && in0_valid;
    m_acc1 = r1 && in1_valid;
    if (!rst) begin
      if (m_acc0) begin
        m_ov = 1; m_od = in0_data; m_ol = in0_last; m_os = 0;
      end else if (m_acc1) begin
        m_ov = 1; m_od = in1_data; m_ol = in1_last; m_os = 1;
      end else if (sf) begin
        m_ov = 0;
      end
      if (m_owner == -1) begin
        if (in0_valid && in1_valid) m_owner = (m_lp == 1) ? 0 : 1;
        else if (in0_valid)         m_owner = 0;
        else if (in1_valid)         m_owner = 1;
      end else if ((m_acc0 && in0_last) || (m_acc1 && in1_last)) begin
        n = m_owner;
        m_lp = n;
        if (n == 0) m_owner = in1_valid ? 1 : -1;
        else        m_owner = in0_valid ? 0 : -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add_beat(input int src, input logic [7:0] d, input logic l, input int gap);
    if (src == 0) q0.push_back('{d: d, l: l, gap: gap});
    else          q1.push_back('{d: d, l: l, gap: gap});
  endtask

  // Drive both sources from their queues, run one cycle, retire accepted beats.
  task automatic drive_step();
    in0_valid = 0; in0_data = '0; in0_last = 0;
    in1_valid = 0; in1_data = '0; in1_last = 0;
    if (q0.size() > 0) begin
      if (q0[0].gap == 0) begin
        in0_valid = 1; in0_data = q0[0].d; in0_last = q0[0].l;
      end
    end
    if (q1.size() > 0) begin
      if (q1[0].gap == 0) begin
        in1_valid = 1; in1_data = q1[0].d; in1_last = q1[0].l;
      end
    end
    if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
    else if (rand_rdy)      out_ready = ($urandom_range(0, 3) != 0);
    else                    out_ready = 1;
    cycle();
    if (m_acc0) void'(q0.pop_front());
    else if (q0.size() > 0 && !in0_valid) q0[0].gap = q0[0].gap - 1;
    if (m_acc1) void'(q1.pop_front());
    else if (q1.size() > 0 && !in1_valid) q1[0].gap = q1[0].gap - 1;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_ov || m_owner != -1) && n < max_cyc) begin
      drive_step();
      n++;
    end
    check("drain_within_budget", n < max_cyc, 1);
  endtask

  task automatic gen_packets(input int src, input int npk);
    int len;
    logic [7:0] d;
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        add_beat(src, d, b == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        if (src == 0) exp0.push_back(d);
        else          exp1.push_back(d);
      end
    end
  endtask

  initial begin
    int n;
    int exp_src[16];
    obs_t prev;

    rst = 1; out_ready = 1;
    in0_valid = 0; in0_data = '0; in0_last = 0;
    in1_valid = 0; in1_data = '0; in1_last = 0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    cycle();
    cycle();
    rst = 0;

    // Contention right after reset: in0 first, in1 on the very next cycle.
    obs_q.delete();
    add_beat(0, 8'hA5, 1, 0);
    add_beat(1, 8'h3C, 1, 0);
    run_until_idle(20);
    check("contend_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("contend_d0", obs_q[0].d, 8'hA5);
      check("contend_s0", obs_q[0].s, 0);
      check("contend_d1", obs_q[1].d, 8'h3C);
      check("contend_s1", obs_q[1].s, 1);
      check("contend_back_to_back", obs_q[1].c - obs_q[0].c, 1);
    end

    // Grant lock: in1 waits behind in0's 3-beat packet.
    obs_q.delete();
    add_beat(0, 8'h01, 0, 0);
    add_beat(0, 8'h02, 0, 0);
    add_beat(0, 8'h03, 1, 0);
    add_beat(1, 8'h55, 1, 0);
    run_until_idle(20);
    check("lock_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("lock_d2", obs_q[2].d, 8'h03);
      check("lock_d3", obs_q[3].d, 8'h55);
      check("lock_s3", obs_q[3].s, 1);
      check("lock_follow", obs_q[3].c - obs_q[2].c, 1);
    end

    // Backpressure for 4 cycles mid-packet: no loss, no duplication.
    obs_q.delete();
    for (int i = 0; i < 4; i++) add_beat(1, 8'(8'h10 + i), i == 3, 0);
    rdy_pat = '{1, 1, 1, 0, 0, 0, 0};
    run_until_idle(30);
    check("bp_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      check("bp_data", obs_q[i].d, 8'h10 + i);

    // Fairness: continuous 2-beat packets alternate by packet.
    obs_q.delete();
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 2; b++) begin
        add_beat(0, 8'(8'h20 + 2 * p + b), b == 1, 0);
        add_beat(1, 8'(8'h40 + 2 * p + b), b == 1, 0);
      end
    end
    run_until_idle(60);
    exp_src = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    check("fair_count", obs_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++)
      check("fair_src", obs_q[i].s, exp_src[i]);

    // Reset mid-packet: in0 served just before, so lp is 0 going into reset.
    obs_q.delete();
    add_beat(0, 8'h66, 1, 0);
    for (int i = 0; i < 4; i++) add_beat(1, 8'(8'hC0 + i), i == 3, 0);
    n = 0;
    while (!(q1.size() == 2 && q0.size() == 0) && n < 40) begin
      drive_step();
      n++;
    end
    check("midrst_reached", n < 40, 1);
    check("midrst_busy_before", busy, 1);
    check("midrst_valid_before", out_valid, 1);
    rst = 1;
    #1;
    check("midrst_out_valid_async", out_valid, 0);
    check("midrst_busy_async", busy, 0);
    check("midrst_in1_ready_async", in1_ready, 0);
    model_reset();
    q1.delete();
    in1_valid = 0; in0_valid = 0;
    cycle();
    rst = 0;
    obs_q.delete();
    add_beat(0, 8'h77, 1, 0);
    add_beat(1, 8'h88, 1, 0);
    run_until_idle(20);
    check("postrst_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("postrst_first_src", obs_q[0].s, 0);
      check("postrst_first_data", obs_q[0].d, 8'h77);
    end

    // Gap inside an in1 packet while in0 waits.
    obs_q.delete();
    add_beat(1, 8'h91, 0, 0);
    add_beat(1, 8'h92, 0, 2);
    add_beat(1, 8'h93, 1, 0);
    add_beat(0, 8'h81, 1, 1);
    run_until_idle(30);
    check("gap_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("gap_d2", obs_q[2].d, 8'h93);
      check("gap_s2", obs_q[2].s, 1);
      check("gap_d3", obs_q[3].d, 8'h81);
      check("gap_s3", obs_q[3].s, 0);
    end

    // Randomized packets with gaps and random backpressure.
    obs_q.delete();
    exp0.delete();
    exp1.delete();
    rand_rdy = 1;
    gen_packets(0, 30);
    gen_packets(1, 30);
    run_until_idle(3000);
    rand_rdy = 0;
    prev = '{d: '0, l: 1'b1, s: 1'b0, c: 0};
    foreach (obs_q[i]) begin
      if (!prev.l) check("rand_no_interleave", obs_q[i].s, prev.s);
      if (obs_q[i].s == 0) begin
        if (exp0.size() > 0) check("rand_src0_data", obs_q[i].d, exp0.pop_front());
        else check("rand_src0_extra", 1, 0);
      end else begin
        if (exp1.size() > 0) check("rand_src1_data", obs_q[i].d, exp1.pop_front());
        else check("rand_src1_extra", 1, 0);
      end
      prev = obs_q[i];
    end
    check("rand_src0_left", exp0.size(), 0);
    check("rand_src1_left", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width of every data port.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in0_valid, in1_valid  input  1 each  requester n offers a beat.
REQ-005 in0_data, in1_data  input  WIDTH each  requester n beat payload.
REQ-006 in0_last, in1_last  input  1 each  beat is the final beat of requester n's packet.
REQ-007 in0_ready, in1_ready  output  1 each  beat from requester n is accepted this cycle.
REQ-008 out_valid  output  1  the output register holds a beat.
REQ-009 out_data  output  WIDTH  the registered payload.
REQ-010 out_last  output  1  the registered last flag.
REQ-011 out_src  output  1  source of the registered beat: 0 = in0, 1 = in1.
REQ-012 out_ready  input  1  the downstream consumer takes the registered beat.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-015 Priority pointer lp: 1 bit, meaning "last served". It SHALL update to n on acceptance of a last beat from requester n.
REQ-016 IDLE, exactly one valid: the next state SHALL be GRANT of that requester.
REQ-017 IDLE, both valid: the next state SHALL be GRANT0 if lp=1, and GRANT1 if lp=0.
REQ-018 IDLE, none valid: the FSM SHALL stay in IDLE.
REQ-019 In IDLE, in0_ready and in1_ready SHALL both be 0.
REQ-020 slot_free SHALL be defined as (!out_valid || out_ready).
REQ-021 In GRANTn, inn_ready SHALL equal slot_free, and the other requester's ready SHALL be 0.
REQ-022 Accept SHALL mean (inn_valid && inn_ready), i.e. valid/ready both high on a rising edge.
REQ-023 On accept, at the next edge: out_data, out_last and out_src SHALL load (inn_data, inn_last, n) and out_valid SHALL become 1.
REQ-024 If slot_free and no accept, out_valid SHALL become 0 at the next edge.
REQ-025 If !slot_free, the output registers SHALL hold their values.
REQ-026 Output payload SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Grant lock: GRANTn SHALL persist across beats until a beat with inn_last=1 is accepted; the other requester's valid SHALL be ignored until then.
REQ-028 On accept of a last beat in GRANTn: if the other requester's valid is high in the same cycle, the next state SHALL be the other GRANT state with no IDLE bubble; otherwise it SHALL be IDLE.
REQ-029 Latency: valid rising in IDLE at edge N SHALL give GRANT at N+1, first accept at N+1 (slot free), and out_valid at N+2.
REQ-030 Throughput SHALL be one beat per cycle within a packet while out_ready=1.
REQ-031 In GRANTn with inn_valid=0 (a mid-packet gap), the FSM SHALL hold GRANTn.
REQ-032 A single-beat packet (last=1 on its first beat) SHALL be legal and SHALL release the grant after that one beat.
REQ-033 out_src SHALL reflect the requester as latched at accept time, independent of the current state.

Reset
REQ-034 While rst=1, all of the following SHALL be forced asynchronously: state=IDLE, lp=1, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, in0_ready=0, in1_ready=0.
REQ-035 A reset asserted mid-packet SHALL drop the partial packet and any held output beat.
REQ-036 After release from reset, arbitration SHALL restart from IDLE, with in0 favoured on the first contention.

Verification
REQ-037 Contention after reset: in0 and in1 both valid with 1-beat packets (0xA5, 0x3C), out_ready=1 -> out beats 0xA5/src0 then 0x3C/src1 on consecutive cycles, with no IDLE cycle between them.
REQ-038 Grant lock: in0 sends a 3-beat packet (0x01, 0x02, 0x03 last) with in1 valid throughout -> in1_ready=0 until 0x03 is accepted, then in1's beat follows next.
REQ-039 Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data holds its value, inn_ready=0, and no beat is lost or duplicated after out_ready returns to 1.
REQ-040 Fairness: both requesters continuously send 2-beat packets -> output sources alternate by packet: 0,0,1,1,0,0,1,1.
REQ-041 Reset mid-packet: rst pulsed after beat 2 of 4 from in1 -> out_valid=0 and busy=0 immediately, without waiting for a clock edge; after release, in0 and in1 both valid -> in0 granted first.
REQ-042 Gap: in1 packet with in1_valid low for 2 cycles between beats while in0 is valid -> grant stays GRANT1 and in0 waits until in1's last beat is accepted.
